// File: rtl/led_pkg.sv
// Shared constants for the LED pixel path: frame geometry, GRB channel layout and the
// per-channel brightness scaler.
package led_pkg;

    localparam int unsigned LED_NUM_LEDS = 150;
    localparam int unsigned LED_IDX_W    = 8;
    localparam int unsigned LED_COLOR_W  = 24;
    localparam int unsigned LED_CHAN_W   = 8;

    // GRB word layout: G = 23:16, R = 15:8, B = 7:0
    localparam int unsigned LED_G_LSB = 16;
    localparam int unsigned LED_R_LSB = 8;
    localparam int unsigned LED_B_LSB = 0;

    // Rounded scale; full-scale brightness passes the channel through untouched.
    function automatic logic [7:0] led_scale_chan(input logic [7:0] chan, input logic [7:0] bright);
        logic [15:0] prod;
        prod = 16'(chan) * 16'(bright) + 16'd128;
        return (bright == 8'hFF) ? chan : prod[15:8];
    endfunction

endpackage

// File: rtl/led_pixel_fifo.sv
// Small first-word-fall-through FIFO carrying a pixel word plus its LED index.
// A push into a full FIFO is dropped unless a pop happens on the same edge.
module led_pixel_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned DataW = 24,
    parameter int unsigned IdxW  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [DataW-1:0] data_i,
    input  logic [IdxW-1:0]  idx_i,
    input  logic             pop_i,
    output logic [DataW-1:0] data_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    logic [DataW-1:0] data_mem_q [Depth];
    logic [IdxW-1:0]  idx_mem_q  [Depth];
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;
    assign data_o  = data_mem_q[rd_ptr_q[PtrW-1:0]];
    assign idx_o   = idx_mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                data_mem_q[i] <= '0;
                idx_mem_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                data_mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
                idx_mem_q[wr_ptr_q[PtrW-1:0]]  <= idx_i;
            end
        end
    end

endmodule

// File: rtl/led_pixel_fetcher.sv
// Fetches the selected LED's GRB word from pixel RAM, scales it and queues it for the serializer.
// Define LED_PIXEL_FETCHER_BRIGHTNESS_EN to apply global brightness; otherwise words pass unscaled.
module led_pixel_fetcher
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = LED_NUM_LEDS,
    parameter int unsigned IDX_W      = LED_IDX_W,
    parameter int unsigned COLOR_W    = LED_COLOR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               led_clock,
    input  logic               led_counter_reset,
    input  logic [IDX_W-1:0]   led_counter,
    input  logic               frame_active,
    input  logic [7:0]         brightness,
    input  logic [COLOR_W-1:0] ram_rdata,
    input  logic               pix_ready,
    output logic [IDX_W-1:0]   ram_addr,
    output logic               ram_re,
    output logic [COLOR_W-1:0] pix_data,
    output logic [IDX_W-1:0]   pix_index,
    output logic               pix_valid,
    output logic               frame_done,
    output logic               overflow
);

    localparam logic [IDX_W-1:0] IdleIdx = IDX_W'(NUM_LEDS);

    logic               fetch;
    logic [IDX_W-1:0]   ram_addr_q, ram_addr_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic               ram_re_q, ram_re_d;
    logic               s1_valid_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic               s2_valid_q;
    logic [IDX_W-1:0]   s2_idx_q;
    logic [COLOR_W-1:0] s2_data_q, s2_data_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic               fifo_empty;
    logic               fifo_drop;
    logic               pop;

    assign fetch = frame_active && (led_counter < IdleIdx) && (led_counter != last_idx_q);

    always_comb begin
        ram_addr_d = ram_addr_q;
        last_idx_d = last_idx_q;
        ram_re_d   = fetch;
        if (fetch) begin
            ram_addr_d = led_counter;
            last_idx_d = led_counter;
        end
    end

    // ram_rdata lines up with S1, so it is scaled on its way into S2
    always_comb begin
        s2_data_d = ram_rdata;
`ifdef LED_PIXEL_FETCHER_BRIGHTNESS_EN
        s2_data_d[LED_G_LSB +: LED_CHAN_W] =
            led_scale_chan(ram_rdata[LED_G_LSB +: LED_CHAN_W], brightness);
        s2_data_d[LED_R_LSB +: LED_CHAN_W] =
            led_scale_chan(ram_rdata[LED_R_LSB +: LED_CHAN_W], brightness);
        s2_data_d[LED_B_LSB +: LED_CHAN_W] =
            led_scale_chan(ram_rdata[LED_B_LSB +: LED_CHAN_W], brightness);
`endif
    end

`ifndef LED_PIXEL_FETCHER_BRIGHTNESS_EN
    logic unused_brightness;
    assign unused_brightness = ^brightness;
`endif

    assign pop          = pix_valid && pix_ready;
    assign frame_done_d = pop && (pix_index == '0);
    assign overflow_d   = overflow_q || fifo_drop;

    always_ff @(posedge led_clock or posedge led_counter_reset) begin
        if (led_counter_reset) begin
            ram_addr_q   <= '0;
            ram_re_q     <= 1'b0;
            last_idx_q   <= IdleIdx;
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_idx_q     <= '0;
            s2_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            ram_addr_q   <= ram_addr_d;
            ram_re_q     <= ram_re_d;
            last_idx_q   <= last_idx_d;
            s1_valid_q   <= ram_re_q;
            s1_idx_q     <= ram_addr_q;
            s2_valid_q   <= s1_valid_q;
            s2_idx_q     <= s1_idx_q;
            s2_data_q    <= s2_data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    led_pixel_fifo #(
        .Depth (FIFO_DEPTH),
        .DataW (COLOR_W),
        .IdxW  (IDX_W)
    ) u_fifo (
        .clk_i   (led_clock),
        .rst_i   (led_counter_reset),
        .push_i  (s2_valid_q),
        .data_i  (s2_data_q),
        .idx_i   (s2_idx_q),
        .pop_i   (pop),
        .data_o  (pix_data),
        .idx_o   (pix_index),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign ram_addr   = ram_addr_q;
    assign ram_re     = ram_re_q;
    assign pix_valid  = !fifo_empty;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_led_pixel_fetcher.sv
// Directed bench for led_pixel_fetcher with a 1-cycle synchronous pixel RAM model.
module tb_led_pixel_fetcher;

    logic        led_clock = 1'b0;
    logic        led_counter_reset = 1'b1;
    logic [7:0]  led_counter = 8'd150;
    logic        frame_active = 1'b0;
    logic [7:0]  brightness = 8'hFF;
    logic [23:0] ram_rdata = '0;
    logic        pix_ready = 1'b0;
    logic [7:0]  ram_addr;
    logic        ram_re;
    logic [23:0] pix_data;
    logic [7:0]  pix_index;
    logic        pix_valid;
    logic        frame_done;
    logic        overflow;

    logic [23:0] ram_mem [256];
    logic [7:0]  pop_idx [$];
    logic [23:0] pop_data [$];
    int          done_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    led_pixel_fetcher dut (
        .led_clock         (led_clock),
        .led_counter_reset (led_counter_reset),
        .led_counter       (led_counter),
        .frame_active      (frame_active),
        .brightness        (brightness),
        .ram_rdata         (ram_rdata),
        .pix_ready         (pix_ready),
        .ram_addr          (ram_addr),
        .ram_re            (ram_re),
        .pix_data          (pix_data),
        .pix_index         (pix_index),
        .pix_valid         (pix_valid),
        .frame_done        (frame_done),
        .overflow          (overflow)
    );

    always #5 led_clock = ~led_clock;

    always @(posedge led_clock) if (ram_re) ram_rdata <= ram_mem[ram_addr];

    // Inputs change 1ns after a rising edge, so a word seen here pops on the next rising edge
    always @(negedge led_clock) begin
        if (pix_valid && pix_ready) begin
            pop_idx.push_back(pix_index);
            pop_data.push_back(pix_data);
        end
        if (frame_done) done_cnt++;
    end

    task automatic step();
        @(posedge led_clock);
        #1;
    endtask

    task automatic clear_log();
        pop_idx.delete();
        pop_data.delete();
        done_cnt = 0;
    endtask

    task automatic apply_reset();
        led_counter_reset = 1'b1;
        frame_active = 1'b0;
        pix_ready = 1'b0;
        led_counter = 8'd150;
        step();
        step();
        led_counter_reset = 1'b0;
        step();
        clear_log();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (ram_addr !== 8'd0 || ram_re !== 1'b0 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fetch: addr=%0d re=%b valid=%b want 0/0/0", ram_addr, ram_re, pix_valid);
        end
        n_cmp++;
        if (frame_done !== 1'b0 || overflow !== 1'b0 || pix_data !== 24'h0 || pix_index !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_out: done=%b ovf=%b data=%h idx=%0d want all 0",
                     frame_done, overflow, pix_data, pix_index);
        end
    endtask

    task automatic test_full_frame();
        apply_reset();
        for (int i = 0; i < 256; i++) ram_mem[i] = {8'(i), 8'(i), 8'(i)};
        brightness = 8'hFF;
        pix_ready = 1'b1;
        frame_active = 1'b1;
        led_counter = 8'd149;
        step();
        n_cmp++;
        if (ram_re !== 1'b1 || ram_addr !== 8'd149) begin
            n_fail++;
            $display("FAIL first_fetch: re=%b addr=%0d want 1/149", ram_re, ram_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++;
            if (pix_valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL latency_e%0d: valid=%b want %b", k, pix_valid, (k == 3));
            end
        end
        for (int i = 148; i >= 0; i--) begin
            led_counter = 8'(i);
            step();
        end
        frame_active = 1'b0;
        led_counter = 8'd150;
        repeat (8) step();
        n_cmp++;
        if (pop_idx.size() != 150) begin
            n_fail++;
            $display("FAIL frame_count: got %0d words want 150", pop_idx.size());
        end else begin
            for (int k = 0; k < 150; k++) begin
                n_cmp++;
                if (pop_idx[k] !== 8'(149 - k) || pop_data[k] !== {3{8'(149 - k)}}) begin
                    n_fail++;
                    $display("FAIL frame_word%0d: idx=%0d data=%h want idx=%0d data=%h", k,
                             pop_idx[k], pop_data[k], 149 - k, {3{8'(149 - k)}});
                end
            end
        end
        n_cmp++;
        if (done_cnt != 1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_flags: done_pulses=%0d ovf=%b want 1/0", done_cnt, overflow);
        end
    endtask

    task automatic test_scaling();
        logic [23:0] exp_word [3];
        logic [7:0]  bright_tab [3];
        logic [23:0] ram_tab [3];
        bright_tab = '{8'd128, 8'd64, 8'd0};
        ram_tab    = '{24'hFF8001, 24'h10FF03, 24'hFFFFFF};
`ifdef LED_PIXEL_FETCHER_BRIGHTNESS_EN
        exp_word   = '{24'h804001, 24'h044001, 24'h000000};
`else
        exp_word   = '{24'hFF8001, 24'h10FF03, 24'hFFFFFF};
`endif
        apply_reset();
        pix_ready = 1'b1;
        frame_active = 1'b1;
        for (int t = 0; t < 3; t++) begin
            brightness = bright_tab[t];
            ram_mem[7 + t] = ram_tab[t];
            led_counter = 8'(7 + t);
            repeat (4) step();
            n_cmp++;
            if (pix_valid !== 1'b1 || pix_index !== 8'(7 + t) || pix_data !== exp_word[t]) begin
                n_fail++;
                $display("FAIL scale%0d: valid=%b idx=%0d data=%h want 1/%0d/%h", t,
                         pix_valid, pix_index, pix_data, 7 + t, exp_word[t]);
            end
        end
        frame_active = 1'b0;
        brightness = 8'hFF;
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 256; i++) ram_mem[i] = {8'(i), 8'(i), 8'(i)};
        pix_ready = 1'b0;
        frame_active = 1'b1;
        for (int k = 0; k < 150; k++) begin
            led_counter = 8'(149 - k);
            step();
            if (k == 6 || k == 7) begin
                n_cmp++;
                if (overflow !== (k == 7)) begin
                    n_fail++;
                    $display("FAIL ovf_push%0d: ovf=%b want %b", k - 2, overflow, (k == 7));
                end
            end
        end
        frame_active = 1'b0;
        led_counter = 8'd150;
        repeat (6) step();
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_index !== 8'd149 || pix_data !== 24'h959595 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_head: valid=%b idx=%0d data=%h ovf=%b want 1/149/959595/1",
                     pix_valid, pix_index, pix_data, overflow);
        end
        pix_ready = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (pop_idx.size() != 4 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_count: got %0d words valid=%b want 4/0", pop_idx.size(), pix_valid);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (pop_idx[k] !== 8'(149 - k)) begin
                    n_fail++;
                    $display("FAIL release_word%0d: idx=%0d want %0d", k, pop_idx[k], 149 - k);
                end
            end
        end
    endtask

    // Relies on the sticky overflow and idle pipeline left behind by test_backpressure
    task automatic test_reset_mid_frame();
        pix_ready = 1'b0;
        frame_active = 1'b1;
        for (int k = 0; k < 6; k++) begin
            led_counter = 8'(149 - k);
            step();
        end
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_index !== 8'd149 || overflow !== 1'b1 || ram_re !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%b idx=%0d ovf=%b re=%b want 1/149/1/1",
                     pix_valid, pix_index, overflow, ram_re);
        end
        #2;
        led_counter_reset = 1'b1;
        #1;
        n_cmp++;
        if (pix_valid !== 1'b0 || ram_re !== 1'b0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b re=%b ovf=%b done=%b want 0/0/0/0",
                     pix_valid, ram_re, overflow, frame_done);
        end
        step();
        led_counter_reset = 1'b0;
        clear_log();
        pix_ready = 1'b1;
        led_counter = 8'd149;
        step();
        n_cmp++;
        if (ram_re !== 1'b1 || ram_addr !== 8'd149) begin
            n_fail++;
            $display("FAIL refetch: re=%b addr=%0d want 1/149", ram_re, ram_addr);
        end
        repeat (3) step();
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_index !== 8'd149) begin
            n_fail++;
            $display("FAIL refetch_out: valid=%b idx=%0d want 1/149", pix_valid, pix_index);
        end
        frame_active = 1'b0;
        repeat (4) step();
        n_cmp++;
        if (pop_idx.size() != 1 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_words: got %0d words valid=%b want 1/0", pop_idx.size(), pix_valid);
        end
    endtask

    task automatic test_repeat_index();
        int re_cnt;
        apply_reset();
        pix_ready = 1'b1;
        frame_active = 1'b1;
        led_counter = 8'd5;
        re_cnt = 0;
        repeat (10) begin
            step();
            if (ram_re) re_cnt++;
        end
        n_cmp++;
        if (re_cnt != 1) begin
            n_fail++;
            $display("FAIL repeat_idx: fetches=%0d want 1", re_cnt);
        end
        led_counter = 8'd200;
        re_cnt = 0;
        repeat (5) begin
            step();
            if (ram_re) re_cnt++;
        end
        n_cmp++;
        if (re_cnt != 0 || ram_addr !== 8'd5) begin
            n_fail++;
            $display("FAIL out_of_range: fetches=%0d addr=%0d want 0/5", re_cnt, ram_addr);
        end
        frame_active = 1'b0;
        led_counter = 8'd4;
        re_cnt = 0;
        repeat (5) begin
            step();
            if (ram_re) re_cnt++;
        end
        n_cmp++;
        if (re_cnt != 0) begin
            n_fail++;
            $display("FAIL inactive: fetches=%0d want 0", re_cnt);
        end
        n_cmp++;
        if (pop_idx.size() != 1 || (pop_idx.size() == 1 && pop_idx[0] !== 8'd5)) begin
            n_fail++;
            $display("FAIL repeat_words: got %0d words want one word idx 5", pop_idx.size());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 256; i++) ram_mem[i] = {8'(i), 8'(i), 8'(i)};
        pix_ready = 1'b0;
        frame_active = 1'b1;
        for (int k = 0; k < 150; k++) begin
            led_counter = 8'(149 - k);
            step();
            if (k == 6) begin
                n_cmp++;
                if (pix_valid !== 1'b1 || pix_index !== 8'd149 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_head: valid=%b idx=%0d ovf=%b want 1/149/0",
                             pix_valid, pix_index, overflow);
                end
                pix_ready = 1'b1;
            end
        end
        frame_active = 1'b0;
        led_counter = 8'd150;
        repeat (8) step();
        n_cmp++;
        if (pop_idx.size() != 150 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words ovf=%b want 150/0", pop_idx.size(), overflow);
        end else begin
            for (int k = 0; k < 150; k++) begin
                n_cmp++;
                if (pop_idx[k] !== 8'(149 - k)) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d: idx=%0d want %0d", k, pop_idx[k], 149 - k);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        test_reset();
        test_full_frame();
        test_scaling();
        test_backpressure();
        test_reset_mid_frame();
        test_repeat_index();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
